// File: rtl/fifo_word_packer_if.sv
// Byte-FIFO read port and packed-word output handshake of the word packer.
// The master modport is the packer; the slave modport is its environment.
interface fifo_word_packer_if #(
   parameter int WIDTH          = 8,
   parameter int BYTES_PER_WORD = 4
);
   localparam int CW = $clog2(BYTES_PER_WORD) + 1;

   logic                            empty;
   logic [WIDTH-1:0]                din;
   logic                            deq;
   logic                            flush;
   logic [WIDTH*BYTES_PER_WORD-1:0] word_out;
   logic [CW-1:0]                   word_bytes;
   logic                            word_valid;
   logic                            word_ready;
   logic                            busy;

   modport master (
      input  empty, din, flush, word_ready,
      output deq, word_out, word_bytes, word_valid, busy
   );

   modport slave (
      output empty, din, flush, word_ready,
      input  deq, word_out, word_bytes, word_valid, busy
   );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops bytes from a 1-cycle-latency FIFO and packs them little-endian into words,
// with a flush request that emits any partially filled word.
module fifo_word_packer #(
   parameter int WIDTH          = 8,
   parameter int BYTES_PER_WORD = 4
) (
   input  logic                clk,
   input  logic                rst,
   fifo_word_packer_if.master  bus
);
   localparam int            CW   = $clog2(BYTES_PER_WORD) + 1;
   localparam int            AW   = WIDTH * BYTES_PER_WORD;
   localparam logic [CW-1:0] FULL = CW'(BYTES_PER_WORD);

   logic [AW-1:0] acc, acc_next, acc_masked;
   logic [CW-1:0] count, count_next, slot;
   logic          inflight;
   logic          flush_pending, flush_pending_next;
   logic [AW-1:0] word_out;
   logic [CW-1:0] word_bytes;
   logic          word_valid;
   logic          deq, slot_free, xfer_full, xfer_flush, xfer, pend_clear;

   always_comb begin
      // Pops reserve accumulator space up front, so count + inflight never exceeds a word.
      deq        = rst && !bus.empty && !flush_pending &&
                   (({1'b0, count} + {{CW{1'b0}}, inflight}) < {1'b0, FULL});
      slot_free  = !word_valid || bus.word_ready;
      xfer_full  = (count == FULL);
      xfer_flush = flush_pending && !inflight && (count != '0);
      xfer       = slot_free && (xfer_full || xfer_flush);
      pend_clear = (slot_free && xfer_flush) || ((count == '0) && !inflight);

      slot       = xfer ? '0 : count;
      acc_next   = xfer ? '0 : acc;
      count_next = xfer ? '0 : count;
      if (inflight) begin
         for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (slot == CW'(k)) acc_next[WIDTH*k +: WIDTH] = bus.din;
         end
         count_next = slot + CW'(1);
      end

      acc_masked = '0;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         if (CW'(k) < count) acc_masked[WIDTH*k +: WIDTH] = acc[WIDTH*k +: WIDTH];
      end

      flush_pending_next = flush_pending ? !pend_clear : bus.flush;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc           <= '0;
         count         <= '0;
         inflight      <= 1'b0;
         flush_pending <= 1'b0;
         word_out      <= '0;
         word_bytes    <= '0;
         word_valid    <= 1'b0;
      end else begin
         acc           <= acc_next;
         count         <= count_next;
         inflight      <= deq;
         flush_pending <= flush_pending_next;
         if (xfer) begin
            word_out   <= acc_masked;
            word_bytes <= count;
            word_valid <= 1'b1;
         end else if (bus.word_ready) begin
            word_valid <= 1'b0;
         end
      end
   end

   assign bus.deq        = deq;
   assign bus.word_out   = word_out;
   assign bus.word_bytes = word_bytes;
   assign bus.word_valid = word_valid;
   assign bus.busy       = (count != '0) || inflight || flush_pending || word_valid;

   count_bound: assert property (@(posedge clk) disable iff (!rst) count <= FULL);
endmodule
